// File: rtl/ex_mem_stage_pkg.sv
// Shared widths and the per-edge action decode for the EX->MEM stage register.
// The action encodes the stall/flush priority: flush, bubble, load, hold.
package ex_mem_stage_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 5;
  localparam int OP_W_DEF    = 8;
  localparam int STALL_W_DEF = 6;
  localparam int EX_IDX_DEF  = 3;
  localparam int MEM_IDX_DEF = 4;
  localparam int CNT_W       = 2;

  typedef enum logic [1:0] {
    ACT_HOLD   = 2'd0,
    ACT_LOAD   = 2'd1,
    ACT_BUBBLE = 2'd2,
    ACT_FLUSH  = 2'd3
  } stage_act_e;

  function automatic stage_act_e stage_action(input logic flush,
                                              input logic ex_stall,
                                              input logic mem_stall);
    if (flush)                  return ACT_FLUSH;
    if (ex_stall && !mem_stall) return ACT_BUBBLE;
    if (!ex_stall)              return ACT_LOAD;
    return ACT_HOLD;
  endfunction

endpackage

// File: rtl/ex_mem_stage_pipe_reg.sv
// Generic pipeline register with clear-over-load priority; latency 1 clk.
// Backpressure: load=0 and clear=0 holds the current contents.
module pipe_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     q <= '0;
    else if (clear) q <= '0;
    else if (load)  q <= d;
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with bubble insertion and madd/msub carry; latency 1 clk.
// Backpressure: EX stall inserts a bubble (carry kept), EX+MEM stall holds everything.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int STALL_W = STALL_W_DEF,
  parameter int EX_IDX  = EX_IDX_DEF,
  parameter int MEM_IDX = MEM_IDX_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic                ex_valid,
  input  logic [DATA_W-1:0]   ex_result,
  input  logic                ex_we,
  input  logic [ADDR_W-1:0]   ex_waddr,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic                ex_whilo,
  input  logic [OP_W-1:0]     ex_op,
  input  logic [DATA_W-1:0]   ex_sdata,
  input  logic [2*DATA_W-1:0] ex_hilo_tmp,
  input  logic [CNT_W-1:0]    ex_cnt,
  output logic                mem_valid,
  output logic [DATA_W-1:0]   mem_result,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic                mem_whilo,
  output logic [OP_W-1:0]     mem_op,
  output logic [DATA_W-1:0]   mem_sdata,
  output logic [2*DATA_W-1:0] hilo_tmp_o,
  output logic [CNT_W-1:0]    cnt_o
);

  localparam int PAY_W   = 4 * DATA_W + ADDR_W + OP_W + 3;
  localparam int CARRY_W = 2 * DATA_W + CNT_W;

  stage_act_e         act;
  logic [PAY_W-1:0]   pay_d;
  logic [PAY_W-1:0]   pay_q;
  logic [CARRY_W-1:0] carry_q;
  logic               stall_unused;

  assign act          = stage_action(flush, stall[EX_IDX], stall[MEM_IDX]);
  assign stall_unused = ^stall;

  // An invalid slot is carried for visibility but must never write GPR or HI/LO.
  assign pay_d = {ex_valid, ex_result, ex_we & ex_valid, ex_waddr,
                  ex_hi, ex_lo, ex_whilo & ex_valid, ex_op, ex_sdata};

  pipe_reg #(.W(PAY_W)) u_payload (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (act == ACT_LOAD),
    .clear ((act == ACT_FLUSH) || (act == ACT_BUBBLE)),
    .d     (pay_d),
    .q     (pay_q)
  );

  // The accumulate carry only survives while EX is stalled waiting on itself.
  pipe_reg #(.W(CARRY_W)) u_carry (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (act == ACT_BUBBLE),
    .clear ((act == ACT_FLUSH) || (act == ACT_LOAD)),
    .d     ({ex_hilo_tmp, ex_cnt}),
    .q     (carry_q)
  );

  assign {mem_valid, mem_result, mem_we, mem_waddr,
          mem_hi, mem_lo, mem_whilo, mem_op, mem_sdata} = pay_q;
  assign {hilo_tmp_o, cnt_o} = carry_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: spec-level model checked every negedge plus directed literal checks.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  stall;
  logic        flush;
  logic        ex_valid;
  logic [31:0] ex_result;
  logic        ex_we;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic        ex_whilo;
  logic [7:0]  ex_op;
  logic [31:0] ex_sdata;
  logic [63:0] ex_hilo_tmp;
  logic [1:0]  ex_cnt;
  logic        mem_valid;
  logic [31:0] mem_result;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_whilo;
  logic [7:0]  mem_op;
  logic [31:0] mem_sdata;
  logic [63:0] hilo_tmp_o;
  logic [1:0]  cnt_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [7:0]  op;
    logic [31:0] sdata;
    logic [63:0] tmp;
    logic [1:0]  cnt;
  } obs_t;

  obs_t m = '0;
  obs_t got;

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_we(ex_we), .ex_waddr(ex_waddr),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo), .ex_op(ex_op),
    .ex_sdata(ex_sdata), .ex_hilo_tmp(ex_hilo_tmp), .ex_cnt(ex_cnt),
    .mem_valid(mem_valid), .mem_result(mem_result), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .mem_op(mem_op), .mem_sdata(mem_sdata), .hilo_tmp_o(hilo_tmp_o), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  assign got = {mem_valid, mem_result, mem_we, mem_waddr, mem_hi, mem_lo,
                mem_whilo, mem_op, mem_sdata, hilo_tmp_o, cnt_o};

  // Reference: what MEM must see after each edge, straight from the priority rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= '0;
    end else if (flush) begin
      m <= '0;
    end else if (stall[3] && !stall[4]) begin
      m     <= '0;
      m.tmp <= ex_hilo_tmp;
      m.cnt <= ex_cnt;
    end else if (!stall[3]) begin
      m.valid  <= ex_valid;
      m.result <= ex_result;
      m.we     <= ex_valid ? ex_we : 1'b0;
      m.waddr  <= ex_waddr;
      m.hi     <= ex_hi;
      m.lo     <= ex_lo;
      m.whilo  <= ex_valid ? ex_whilo : 1'b0;
      m.op     <= ex_op;
      m.sdata  <= ex_sdata;
      m.tmp    <= 64'd0;
      m.cnt    <= 2'd0;
    end
  end

  always @(posedge clk) begin
    if (rst_n) assert (!(stall[4] && !stall[3])) else $error("illegal stall pattern %b", stall);
  end

  always @(negedge clk) begin
    checks++;
    if (got !== m) begin
      errors++;
      $display("FAIL model_cmp t=%0t got=%h exp=%h", $time, got, m);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
    end
  endtask

  task automatic idle();
    stall = '0; flush = 0; ex_valid = 0; ex_result = '0; ex_we = 0; ex_waddr = '0;
    ex_hi = '0; ex_lo = '0; ex_whilo = 0; ex_op = '0; ex_sdata = '0;
    ex_hilo_tmp = '0; ex_cnt = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [5:0] PAT [8] = '{6'b000000, 6'b001111, 6'b011111, 6'b000000,
                                     6'b001111, 6'b001111, 6'b011111, 6'b000000};

  initial begin
    idle();
    #2;
    chk("reset_valid", 64'(mem_valid), 64'd0);
    chk("reset_tmp", hilo_tmp_o, 64'd0);
    @(negedge clk);
    rst_n = 1;

    // basic load
    ex_valid = 1; ex_result = 32'h1234_5678; ex_we = 1; ex_waddr = 5'd9;
    ex_hi = 32'h1; ex_lo = 32'h2; ex_whilo = 1; ex_op = 8'h23; ex_sdata = 32'hDEAD;
    tick();
    chk("load_result", 64'(mem_result), 64'h1234_5678);
    chk("load_we", 64'(mem_we), 64'd1);
    chk("load_waddr", 64'(mem_waddr), 64'd9);
    chk("load_valid", 64'(mem_valid), 64'd1);

    // EX-only stall: bubble plus carry
    stall = 6'b001111; ex_hilo_tmp = 64'hA5; ex_cnt = 2'd1;
    tick();
    chk("bubble_valid", 64'(mem_valid), 64'd0);
    chk("bubble_we", 64'(mem_we), 64'd0);
    chk("bubble_tmp", hilo_tmp_o, 64'hA5);
    chk("bubble_cnt", 64'(cnt_o), 64'd1);
    stall = '0;
    tick();
    chk("release_tmp", hilo_tmp_o, 64'd0);
    chk("release_cnt", 64'(cnt_o), 64'd0);
    chk("release_valid", 64'(mem_valid), 64'd1);

    // both stalled: hold loaded instruction
    ex_result = 32'h0BAD_F00D; ex_waddr = 5'd3;
    tick();
    stall = 6'b011111; ex_result = 32'hFFFF_FFFF; ex_waddr = 5'd31;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_result", 64'(mem_result), 64'h0BAD_F00D);
      chk("hold_valid", 64'(mem_valid), 64'd1);
      chk("hold_waddr", 64'(mem_waddr), 64'd3);
    end

    // both stalled: hold carry
    stall = 6'b001111; ex_hilo_tmp = 64'h77; ex_cnt = 2'd2;
    tick();
    stall = 6'b011111; ex_hilo_tmp = 64'h99; ex_cnt = 2'd0;
    tick();
    chk("hold_tmp", hilo_tmp_o, 64'h77);
    chk("hold_cnt", 64'(cnt_o), 64'd2);

    // flush beats a plain load
    stall = '0; ex_result = 32'h600D;
    tick();
    flush = 1;
    tick();
    chk("flush_valid", 64'(mem_valid), 64'd0);
    chk("flush_result", 64'(mem_result), 64'd0);
    chk("flush_we", 64'(mem_we), 64'd0);
    chk("flush_sdata", 64'(mem_sdata), 64'd0);

    // flush beats both-stalled hold of the carry
    flush = 0; stall = 6'b001111; ex_hilo_tmp = 64'h3C; ex_cnt = 2'd1;
    tick();
    flush = 1; stall = 6'b011111;
    tick();
    chk("flush_tmp", hilo_tmp_o, 64'd0);
    chk("flush_cnt", 64'(cnt_o), 64'd0);

    // invalid slot never writes
    flush = 0; stall = '0; ex_valid = 0; ex_we = 1; ex_whilo = 1; ex_result = 32'h55;
    tick();
    chk("inv_we", 64'(mem_we), 64'd0);
    chk("inv_whilo", 64'(mem_whilo), 64'd0);
    chk("inv_valid", 64'(mem_valid), 64'd0);
    chk("inv_result", 64'(mem_result), 64'h55);

    // async reset mid-cycle, then release during an EX stall
    ex_valid = 1; ex_result = 32'hCAFE; ex_waddr = 5'd7;
    tick();
    #1 rst_n = 0;
    #1;
    chk("arst_result", 64'(mem_result), 64'd0);
    chk("arst_valid", 64'(mem_valid), 64'd0);
    chk("arst_waddr", 64'(mem_waddr), 64'd0);
    stall = 6'b001111; ex_hilo_tmp = 64'h1234; ex_cnt = 2'd3;
    @(posedge clk);
    #2 rst_n = 1;
    tick();
    chk("rel_tmp", hilo_tmp_o, 64'h1234);
    chk("rel_cnt", 64'(cnt_o), 64'd3);
    chk("rel_valid", 64'(mem_valid), 64'd0);

    // mixed sequence, checked by the model each cycle
    for (int i = 0; i < 24; i++) begin
      stall       = PAT[i % 8];
      flush       = (i % 7 == 6);
      ex_valid    = (i % 3 != 0);
      ex_result   = 32'h0101_0101 * (i + 1);
      ex_we       = i[0];
      ex_waddr    = 5'(i);
      ex_hi       = 32'hF000_0000 + 32'(i);
      ex_lo       = 32'h0000_F000 + 32'(i);
      ex_whilo    = i[1];
      ex_op       = 8'(i * 3);
      ex_sdata    = ~ex_result;
      ex_hilo_tmp = {32'(i), 32'hAAAA_0000 + 32'(i)};
      ex_cnt      = 2'(i);
      tick();
    end

    idle();
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
